fetch_unit: RTL and testbench

- Producer side of the fetch/decode pipeline latch.
- Generates the fetch PC and issues word reads to instruction memory over a valid/ready request and in-order response interface.
- Buffers returned instructions with their PCs and presents {fd_pc, fd_ir, fd_valid} to the F/D latch.
- Honours downstream stall, and branch redirect/flush from execute.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd1;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          FD_ENTRY_W       = 64;

    // One buffered instruction as presented to the F/D latch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fd_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO used for the PC queue and the fetched-instruction queue.
module fetch_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty queue is ignored; a push into a full queue only lands
    // when the same cycle also frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word reads, tracks their PCs, and presents fetched instructions to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_ir
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] inflight;
    logic [CW-1:0] buffered;
    logic [OW-1:0] occ;
    logic          req_fire;
    logic          rsp_keep;
    logic          out_pop;
    logic [31:0]   pcq_head;
    fd_entry_t     out_push;
    fd_entry_t     out_head;

    // Responses still owed to a flushed stream count against capacity until they drain.
    assign occ = OW'(inflight) + OW'(buffered) + OW'(drop_cnt);

    assign imem_req_valid = !reset && !redirect && (occ < OW'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep = imem_rsp_valid && !redirect && (drop_cnt == '0);
    assign out_push = '{pc: pcq_head, ir: imem_rsp_data};

    // Presented values come straight off registered queue state, so they only move on edges.
    assign fd_valid = (buffered != '0);
    assign out_pop  = fd_valid && !stall;
    assign fd_pc    = fd_valid ? out_head.pc : 32'h0;
    assign fd_ir    = fd_valid ? out_head.ir : NOP_INSN;

    always_comb begin
        // NOTE: default first so every path assigns drop_nxt and no latch is inferred.
        drop_nxt = drop_cnt;
        if (redirect) begin
            drop_nxt = CW'(OW'(drop_cnt) + OW'(inflight) - (imem_rsp_valid ? OW'(1) : OW'(0)));
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
        end
    end

    fetch_buf #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .head_data (pcq_head),
        .count     (inflight)
    );

    fetch_buf #(
        .WIDTH (FD_ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_out_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_keep),
        .push_data (out_push),
        .pop       (out_pop),
        .head_data (out_head),
        .count     (buffered)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model and an expected-PC scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_ir;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    bit mon_en = 1'b0;

    logic [31:0] model_pc = RST_PC;
    logic [31:0] exp_q[$];

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t mq[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fd_valid       (fd_valid),
        .fd_pc          (fd_pc),
        .fd_ir          (fd_ir)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fd_valid) return;
        end
        check("wait_fd_valid", 64'(fd_valid), 64'd1);
    endtask

    task automatic wait_fd_pc(input logic [31:0] pc, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fd_valid && fd_pc == pc) return;
        end
        check("wait_fd_pc", {31'b0, fd_valid, fd_pc}, {32'd1, pc});
    endtask

    // Memory: accepted at edge t, response driven in the cycle after edge t+lat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].data;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{due: cyc + lat, data: mem_word(imem_req_addr)});
        end
    end

    // Scoreboard: expected PCs queued at request time, compared when decode consumes.
    initial begin : monitor
        logic [31:0] e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                model_pc = RST_PC;
            end else if (redirect) begin
                check("no_req_in_redirect", 64'(imem_req_valid), 64'd0);
                exp_q.delete();
                model_pc = redirect_pc;
            end else begin
                if (!fd_valid) begin
                    check("idle_fd_ir", fd_ir, NOP_INSN);
                end else if (!stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_fd_valid", 64'(fd_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("fd_pc", fd_pc, e);
                        check("fd_ir", fd_ir, mem_word(e));
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, model_pc);
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd1;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] held;

        // Reset state
        step(3);
        check("reset_fd_valid", 64'(fd_valid), 64'd0);
        check("reset_fd_pc", fd_pc, 32'h0);
        check("reset_fd_ir", fd_ir, NOP_INSN);
        check("reset_req_valid", 64'(imem_req_valid), 64'd0);
        check("reset_req_addr", imem_req_addr, RST_PC);
        mon_en = 1'b1;
        reset  = 1'b0;

        // First instruction: accepted at edge 1, response after edge 2, fd after edge 3
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("lat_fd_valid", 64'(fd_valid), 64'(i == 3));
        end
        check("lat_fd_pc", fd_pc, RST_PC);

        // Stall while PC 4 is presented
        wait_fd_pc(32'd4, 40);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_fd_pc", fd_pc, 32'd4);
            check("stall_fd_ir", fd_ir, mem_word(32'd4));
        end
        check("stall_req_blocked", 64'(imem_req_valid), 64'd0);
        stall = 1'b0;
        step(6);

        // Drain, fetch 8 and 9 with L=3, redirect while both are in flight
        imem_req_ready = 1'b0;
        step(10);
        check("drain_idle", 64'(fd_valid), 64'd0);
        redirect = 1'b1; redirect_pc = 32'd8;
        step(1);
        redirect = 1'b0;
        lat = 3;
        imem_req_ready = 1'b1;
        step(2);
        imem_req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("redirect_req_valid", 64'(imem_req_valid), 64'd0);
        step(1);
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        wait_fd(40);
        check("redirect_first_pc", fd_pc, 32'h100);
        imem_req_ready = 1'b0;
        step(12);
        lat = 1;
        imem_req_ready = 1'b1;

        // Redirect and stall together while an instruction is presented
        stall = 1'b1;
        wait_fd(20);
        redirect = 1'b1; redirect_pc = 32'h200;
        step(1);
        check("flush_fd_valid", 64'(fd_valid), 64'd0);
        redirect = 1'b0;
        stall = 1'b0;
        step(8);

        // Memory not ready for 4 cycles: address held
        imem_req_ready = 1'b0;
        step(1);
        held = model_pc;
        for (int i = 0; i < 4; i++) begin
            check("held_req_addr", imem_req_addr, held);
            step(1);
        end
        imem_req_ready = 1'b1;
        step(10);

        // PC wrap-around, then reset in the middle of the stream
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step(1);
        redirect = 1'b0;
        wait_fd_pc(32'h0, 40);
        step(2);
        reset = 1'b1;
        step(1);
        check("midreset_fd_valid", 64'(fd_valid), 64'd0);
        check("midreset_fd_pc", fd_pc, 32'h0);
        check("midreset_fd_ir", fd_ir, NOP_INSN);
        check("midreset_req_valid", 64'(imem_req_valid), 64'd0);
        step(1);
        reset = 1'b0;
        #1;
        check("postreset_req_valid", 64'(imem_req_valid), 64'd1);
        check("postreset_req_addr", imem_req_addr, RST_PC);
        step(10);

        imem_req_ready = 1'b0;
        step(10);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
